// File: rtl/time_dmr_retry_scheduler.sv
// Issue controller for a time-DMR start/end pair: assigns IDs, keeps
// in-flight payloads, re-issues on needs_retry and frees IDs on completion.
module time_dmr_retry_scheduler #(
  parameter type         DataType   = logic [7:0],
  parameter int unsigned IDSize     = 4,
  parameter int unsigned MaxRetries = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              fb_valid_i,
  input  logic [IDSize-1:0] fb_id_i,
  input  logic              fb_retry_i,
  output logic              drop_o,
  output logic [IDSize-1:0] drop_id_o,
  output logic              spurious_o,
  output logic              busy_o
);

  localparam int unsigned Depth = 2 ** IDSize;
  localparam int unsigned CntW  = $clog2(MaxRetries + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_NEW,
    HOLD_RETRY
  } state_e;

  state_e            state_q;
  logic              mode_q;
  DataType           slot_data_q;
  logic [IDSize-1:0] slot_id_q;
  logic              drop_q;
  logic [IDSize-1:0] drop_id_q;
  logic              spur_q;

  logic [Depth-1:0]  busy_q;
  DataType           tbl_data_q [Depth];
  logic [CntW-1:0]   cnt_q [Depth];
  logic [IDSize-1:0] ptr_q;

  logic [IDSize-1:0] rq_q [Depth];
  logic [IDSize-1:0] rq_rd_q;
  logic [IDSize-1:0] rq_wr_q;
  logic [IDSize:0]   rq_cnt_q;

  logic              slot_free;
  logic              rq_empty;
  logic              new_rdy;
  logic              pop;
  logic              accept;
  logic              fb_act;
  logic              fb_hit;
  logic [CntW-1:0]   fb_cnt;
  logic              at_max;
  logic              push;
  logic              fb_free;
  logic              fb_drop;
  logic [IDSize-1:0] rq_head;

  assign slot_free = (state_q == IDLE) | ready_i;
  assign rq_empty  = (rq_cnt_q == '0);
  assign new_rdy   = slot_free & rq_empty & ~busy_q[ptr_q];
  assign pop       = mode_q & slot_free & ~rq_empty;
  assign accept    = mode_q & new_rdy & valid_i;
  assign rq_head   = rq_q[rq_rd_q];

  assign fb_act  = mode_q & fb_valid_i;
  assign fb_hit  = fb_act & busy_q[fb_id_i];
  assign fb_cnt  = cnt_q[fb_id_i];
  assign at_max  = (fb_cnt == CntW'(MaxRetries));
  assign push    = fb_hit & fb_retry_i & ~at_max;
  assign fb_drop = fb_hit & fb_retry_i & at_max;
  assign fb_free = fb_hit & (~fb_retry_i | at_max);

  assign ready_o    = mode_q ? new_rdy : ready_i;
  assign valid_o    = mode_q ? (state_q != IDLE) : valid_i;
  assign data_o     = mode_q ? slot_data_q : data_i;
  assign id_o       = mode_q ? slot_id_q : '0;
  assign busy_o     = mode_q ? ((|busy_q) | (state_q != IDLE)) : valid_i;
  assign drop_o     = drop_q;
  assign drop_id_o  = drop_id_q;
  assign spurious_o = spur_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      slot_data_q <= '0;
      slot_id_q   <= '0;
      drop_q      <= 1'b0;
      drop_id_q   <= '0;
      spur_q      <= 1'b0;
    end else begin
      // Mode only switches when nothing is in flight
      if (state_q == IDLE && busy_q == '0) begin
        mode_q <= enable_i;
      end
      spur_q <= fb_act & ~busy_q[fb_id_i];
      drop_q <= fb_drop;
      if (fb_drop) begin
        drop_id_q <= fb_id_i;
      end
      if (mode_q) begin
        if (pop) begin
          state_q     <= HOLD_RETRY;
          slot_data_q <= tbl_data_q[rq_head];
          slot_id_q   <= rq_head;
        end else if (accept) begin
          state_q     <= HOLD_NEW;
          slot_data_q <= data_i;
          slot_id_q   <= ptr_q;
        end else if (ready_i) begin
          state_q <= IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      ptr_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        tbl_data_q[i] <= '0;
        cnt_q[i]      <= '0;
      end
    end else begin
      if (accept) begin
        busy_q[ptr_q]     <= 1'b1;
        tbl_data_q[ptr_q] <= data_i;
        cnt_q[ptr_q]      <= '0;
        ptr_q             <= ptr_q + IDSize'(1);
      end
      // Feedback targets a busy ID, allocation a free one: never the same entry
      if (fb_free) begin
        busy_q[fb_id_i] <= 1'b0;
        cnt_q[fb_id_i]  <= '0;
      end else if (push) begin
        cnt_q[fb_id_i] <= fb_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rq_rd_q  <= '0;
      rq_wr_q  <= '0;
      rq_cnt_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        rq_q[i] <= '0;
      end
    end else begin
      if (push) begin
        rq_q[rq_wr_q] <= fb_id_i;
        rq_wr_q       <= rq_wr_q + IDSize'(1);
      end
      if (pop) begin
        rq_rd_q <= rq_rd_q + IDSize'(1);
      end
      rq_cnt_q <= rq_cnt_q + (IDSize + 1)'(push) - (IDSize + 1)'(pop);
    end
  end

endmodule

// File: tb/tb_time_dmr_retry_scheduler.sv
// Directed bench for time_dmr_retry_scheduler: passthrough, clean flow,
// retries, retry limit, table full, stall, spurious feedback and reset.
module tb_time_dmr_retry_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       enable_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic [3:0] id_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic       fb_valid_i = 1'b0;
  logic [3:0] fb_id_i = '0;
  logic       fb_retry_i = 1'b0;
  logic       drop_o;
  logic [3:0] drop_id_o;
  logic       spurious_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  time_dmr_retry_scheduler dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .id_o       (id_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .fb_valid_i (fb_valid_i),
    .fb_id_i    (fb_id_i),
    .fb_retry_i (fb_retry_i),
    .drop_o     (drop_o),
    .drop_id_o  (drop_id_o),
    .spurious_o (spurious_o),
    .busy_o     (busy_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i    = 1'b0;
    data_i     = '0;
    fb_valid_i = 1'b0;
    fb_id_i    = '0;
    fb_retry_i = 1'b0;
    ready_i    = 1'b1;
  endtask

  task automatic do_reset(input logic en);
    idle_inputs();
    enable_i = en;
    rst_ni   = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    ready_i  = 1'b0;
    enable_i = 1'b0;
    step();
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({valid_o, data_o, id_o} !== 13'd0) begin
      fails++;
      $display("FAIL rst_out got v=%b d=%h id=%h exp 0/00/0", valid_o, data_o, id_o);
    end
    tests++;
    if ({drop_o, drop_id_o, spurious_o, busy_o} !== 7'd0) begin
      fails++;
      $display("FAIL rst_flags got drop=%b did=%h sp=%b busy=%b exp 0", drop_o, drop_id_o, spurious_o, busy_o);
    end
    do_reset(1'b1);
    tests++;
    if ({valid_o, busy_o, ready_o} !== 3'b001) begin
      fails++;
      $display("FAIL rst_mode1 got v=%b busy=%b rdy=%b exp 0/0/1", valid_o, busy_o, ready_o);
    end
  endtask

  task automatic test_passthrough();
    do_reset(1'b0);
    for (int i = 0; i < 1000; i++) begin
      data_i     = 8'($urandom);
      valid_i    = 1'($urandom_range(0, 1));
      ready_i    = 1'($urandom_range(0, 1));
      fb_valid_i = 1'($urandom_range(0, 1));
      fb_id_i    = 4'($urandom);
      fb_retry_i = 1'($urandom_range(0, 1));
      #1;
      tests++;
      if ({data_o, valid_o, ready_o, id_o, busy_o} !== {data_i, valid_i, ready_i, 4'd0, valid_i}) begin
        fails++;
        $display("FAIL pt_comb got d=%h v=%b r=%b id=%h b=%b exp d=%h v=%b r=%b id=0", data_o, valid_o, ready_o, id_o, busy_o, data_i, valid_i, ready_i);
      end
      tests++;
      if ({spurious_o, drop_o} !== 2'b00) begin
        fails++;
        $display("FAIL pt_fb got sp=%b drop=%b exp 0/0", spurious_o, drop_o);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_clean_flow();
    do_reset(1'b1);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        tests++;
        if ({valid_o, data_o, id_o} !== {1'b1, 8'(k - 1), 4'(k - 1)}) begin
          fails++;
          $display("FAIL cf_issue%0d got v=%b d=%h id=%0d exp v=1 d=%h id=%0d", k - 1, valid_o, data_o, id_o, 8'(k - 1), 4'(k - 1));
        end
        fb_valid_i = 1'b1;
        fb_id_i    = 4'(k - 1);
        fb_retry_i = 1'b0;
      end
      if (k < 20) begin
        valid_i = 1'b1;
        data_i  = 8'(k);
        #1;
        tests++;
        if (ready_o !== 1'b1) begin
          fails++;
          $display("FAIL cf_ready%0d got %b exp 1", k, ready_o);
        end
      end else begin
        valid_i = 1'b0;
      end
      step();
    end
    fb_valid_i = 1'b0;
    tests++;
    if ({valid_o, busy_o} !== 2'b00) begin
      fails++;
      $display("FAIL cf_done got v=%b busy=%b exp 0/0", valid_o, busy_o);
    end
  endtask

  task automatic test_single_retry();
    do_reset(1'b1);
    valid_i = 1'b1;
    data_i  = 8'h10;
    step();
    data_i     = 8'h11;
    fb_valid_i = 1'b1;
    fb_id_i    = 4'd0;
    step();
    data_i  = 8'hA5;
    fb_id_i = 4'd1;
    step();
    tests++;
    if ({valid_o, data_o, id_o} !== {1'b1, 8'hA5, 4'd2}) begin
      fails++;
      $display("FAIL sr_first got v=%b d=%h id=%0d exp 1/a5/2", valid_o, data_o, id_o);
    end
    valid_i    = 1'b0;
    fb_id_i    = 4'd2;
    fb_retry_i = 1'b1;
    step();
    fb_valid_i = 1'b0;
    fb_retry_i = 1'b0;
    valid_i    = 1'b1;
    data_i     = 8'h33;
    #1;
    tests++;
    if ({valid_o, ready_o} !== 2'b00) begin
      fails++;
      $display("FAIL sr_block got v=%b rdy=%b exp 0/0", valid_o, ready_o);
    end
    step();
    tests++;
    if ({valid_o, data_o, id_o} !== {1'b1, 8'hA5, 4'd2}) begin
      fails++;
      $display("FAIL sr_reissue got v=%b d=%h id=%0d exp 1/a5/2", valid_o, data_o, id_o);
    end
    fb_valid_i = 1'b1;
    fb_id_i    = 4'd2;
    step();
    tests++;
    if ({valid_o, data_o, id_o} !== {1'b1, 8'h33, 4'd3}) begin
      fails++;
      $display("FAIL sr_new got v=%b d=%h id=%0d exp 1/33/3", valid_o, data_o, id_o);
    end
    valid_i = 1'b0;
    fb_id_i = 4'd3;
    step();
    fb_valid_i = 1'b0;
    step();
    tests++;
    if ({valid_o, busy_o} !== 2'b00) begin
      fails++;
      $display("FAIL sr_freed got v=%b busy=%b exp 0/0", valid_o, busy_o);
    end
  endtask

  task automatic test_retry_limit();
    do_reset(1'b1);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        tests++;
        if ({valid_o, data_o, id_o} !== {1'b1, 8'(8'h50 + k - 1), 4'(k - 1)}) begin
          fails++;
          $display("FAIL rl_issue%0d got v=%b d=%h id=%0d", k - 1, valid_o, data_o, id_o);
        end
        fb_valid_i = 1'b1;
        fb_id_i    = 4'(k - 1);
        fb_retry_i = (k == 6);
      end
      valid_i = (k < 6);
      data_i  = 8'(8'h50 + k);
      step();
    end
    for (int r = 1; r <= 3; r++) begin
      fb_valid_i = 1'b0;
      tests++;
      if ({valid_o, drop_o} !== 2'b00) begin
        fails++;
        $display("FAIL rl_gap%0d got v=%b drop=%b exp 0/0", r, valid_o, drop_o);
      end
      step();
      tests++;
      if ({valid_o, data_o, id_o} !== {1'b1, 8'h55, 4'd5}) begin
        fails++;
        $display("FAIL rl_reissue%0d got v=%b d=%h id=%0d exp 1/55/5", r, valid_o, data_o, id_o);
      end
      fb_valid_i = 1'b1;
      fb_id_i    = 4'd5;
      fb_retry_i = 1'b1;
      step();
    end
    fb_valid_i = 1'b0;
    fb_retry_i = 1'b0;
    tests++;
    if ({drop_o, drop_id_o, valid_o} !== {1'b1, 4'd5, 1'b0}) begin
      fails++;
      $display("FAIL rl_drop got drop=%b id=%0d v=%b exp 1/5/0", drop_o, drop_id_o, valid_o);
    end
    step();
    tests++;
    if ({drop_o, valid_o, busy_o} !== 3'b000) begin
      fails++;
      $display("FAIL rl_after got drop=%b v=%b busy=%b exp 0/0/0", drop_o, valid_o, busy_o);
    end
  endtask

  task automatic test_table_full();
    do_reset(1'b1);
    for (int k = 0; k < 16; k++) begin
      valid_i = 1'b1;
      data_i  = 8'(8'h80 + k);
      #1;
      tests++;
      if (ready_o !== 1'b1) begin
        fails++;
        $display("FAIL tf_ready%0d got %b exp 1", k, ready_o);
      end
      step();
    end
    data_i = 8'hEE;
    #1;
    tests++;
    if ({valid_o, id_o, ready_o} !== {1'b1, 4'd15, 1'b0}) begin
      fails++;
      $display("FAIL tf_full got v=%b id=%0d rdy=%b exp 1/15/0", valid_o, id_o, ready_o);
    end
    step();
    tests++;
    if ({valid_o, ready_o} !== 2'b00) begin
      fails++;
      $display("FAIL tf_idle got v=%b rdy=%b exp 0/0", valid_o, ready_o);
    end
    fb_valid_i = 1'b1;
    fb_id_i    = 4'd0;
    fb_retry_i = 1'b0;
    step();
    fb_valid_i = 1'b0;
    #1;
    tests++;
    if (ready_o !== 1'b1) begin
      fails++;
      $display("FAIL tf_freed got rdy=%b exp 1", ready_o);
    end
    step();
    valid_i = 1'b0;
    tests++;
    if ({valid_o, data_o, id_o} !== {1'b1, 8'hEE, 4'd0}) begin
      fails++;
      $display("FAIL tf_reuse got v=%b d=%h id=%0d exp 1/ee/0", valid_o, data_o, id_o);
    end
  endtask

  task automatic test_stall_spurious();
    do_reset(1'b1);
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h3C;
    step();
    data_i = 8'h77;
    for (int s = 0; s < 5; s++) begin
      tests++;
      if ({valid_o, data_o, id_o, ready_o} !== {1'b1, 8'h3C, 4'd0, 1'b0}) begin
        fails++;
        $display("FAIL st_hold%0d got v=%b d=%h id=%0d rdy=%b exp 1/3c/0/0", s, valid_o, data_o, id_o, ready_o);
      end
      tests++;
      if (spurious_o !== (s == 1)) begin
        fails++;
        $display("FAIL st_spur%0d got %b exp %b", s, spurious_o, (s == 1));
      end
      fb_valid_i = (s == 0);
      fb_id_i    = 4'd9;
      fb_retry_i = 1'b1;
      if (s == 4) ready_i = 1'b1;
      step();
    end
    fb_retry_i = 1'b0;
    tests++;
    if ({valid_o, data_o, id_o} !== {1'b1, 8'h77, 4'd1}) begin
      fails++;
      $display("FAIL st_next got v=%b d=%h id=%0d exp 1/77/1", valid_o, data_o, id_o);
    end
    valid_i = 1'b0;
    step();
    step();
    tests++;
    if ({valid_o, busy_o} !== 2'b01) begin
      fails++;
      $display("FAIL st_noretry got v=%b busy=%b exp 0/1", valid_o, busy_o);
    end
  endtask

  task automatic test_reset_midop();
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({valid_o, busy_o} !== 2'b00) begin
      fails++;
      $display("FAIL rm_clear got v=%b busy=%b exp 0/0", valid_o, busy_o);
    end
    step();
    rst_ni   = 1'b1;
    enable_i = 1'b1;
    step();
    step();
    fb_valid_i = 1'b1;
    fb_id_i    = 4'd0;
    fb_retry_i = 1'b0;
    step();
    fb_valid_i = 1'b0;
    tests++;
    if (spurious_o !== 1'b1) begin
      fails++;
      $display("FAIL rm_spur got %b exp 1", spurious_o);
    end
    step();
    tests++;
    if ({spurious_o, busy_o} !== 2'b00) begin
      fails++;
      $display("FAIL rm_after got sp=%b busy=%b exp 0/0", spurious_o, busy_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthrough();
    test_clean_flow();
    test_single_retry();
    test_retry_limit();
    test_table_full();
    test_stall_spurious();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
